// File: rtl/seg7_scan_capture.sv
// Read-back monitor for a multiplexed active-low 7-segment display: it qualifies
// stable scan samples, decodes each selected digit back to BCD and reports completed frames.
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            SEG,
    input  logic [DIGITS-1:0]     AN,
    input  logic                  CLR,
    output logic [4*DIGITS-1:0]   DIGIT_VAL,
    output logic [DIGITS-1:0]     DP_VAL,
    output logic [DIGITS-1:0]     ERR_FLAGS,
    output logic                  ERR,
    output logic                  FRAME_VALID
);

    localparam int SW = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]       smp;
    logic [SW-1:0]       s_q;
    logic [CW-1:0]       cnt_q;
    logic                captured_q;
    logic [DIGITS-1:0]   mask_q;
    logic [DIGITS-1:0]   sel;
    logic [DIGITS-1:0]   mask_set;
    logic [7:0]          seg_s;
    logic                same;
    logic                one_hot;
    logic                capture;
    logic                frame_done;
    logic [4:0]          dec;

    // Returns {invalid, bcd}; segment bits are g..a, active-low.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    assign smp     = {AN, SEG};
    assign seg_s   = s_q[7:0];
    assign sel     = ~s_q[SW-1:8];
    assign same    = (smp == s_q);
    // Blanking (no anode) and overlap (several anodes) are never captured.
    assign one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign capture = same && (cnt_q == CNT_MAX) && !captured_q && one_hot;
    assign dec     = decode(seg_s[6:0]);

    assign mask_set   = mask_q | (capture ? sel : '0);
    assign frame_done = capture && (&mask_set);

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_q         <= '0;
            cnt_q       <= '0;
            captured_q  <= 1'b0;
            mask_q      <= '0;
            DIGIT_VAL   <= '0;
            DP_VAL      <= '1;
            ERR_FLAGS   <= '0;
            ERR         <= 1'b0;
            FRAME_VALID <= 1'b0;
        end else begin
            s_q <= smp;

            if (!same) begin
                cnt_q      <= '0;
                captured_q <= 1'b0;
            end else begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                if (capture) captured_q <= 1'b1;
            end

            // Data fields follow a capture even when CLR wipes the status bits.
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && sel[i]) begin
                    DIGIT_VAL[4*i +: 4] <= dec[3:0];
                    DP_VAL[i]           <= seg_s[7];
                end
            end

            FRAME_VALID <= frame_done && !CLR;

            if (CLR || frame_done) mask_q <= '0;
            else                   mask_q <= mask_set;

            if (CLR) begin
                ERR_FLAGS <= '0;
                ERR       <= 1'b0;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (capture && sel[i]) ERR_FLAGS[i] <= dec[4];
                end
                if (capture && dec[4]) ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        clr;
    logic [15:0] digit_val;
    logic [3:0]  dp_val;
    logic [3:0]  err_flags;
    logic        err;
    logic        frame_valid;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PX = 7'b1111111;

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .CLK(clk),
        .RST(rst),
        .SEG(seg),
        .AN(an),
        .CLR(clr),
        .DIGIT_VAL(digit_val),
        .DP_VAL(dp_val),
        .ERR_FLAGS(err_flags),
        .ERR(err),
        .FRAME_VALID(frame_valid)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic dp, input logic [6:0] p);
        an  = a;
        seg = {dp, p};
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        an  = 4'hF;
        seg = 8'hFF;
        step(2);
        rst = 1'b0;
        check("rst_digit", {16'h0, digit_val}, 32'h0);
        check("rst_dp", {28'h0, dp_val}, 32'hF);
        check("rst_flags", {28'h0, err_flags}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_fv", {31'h0, frame_valid}, 32'h0);

        // latency: first sample at edge 0, capture at edge 4
        drive(4'b1110, 1'b1, P2);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("lat_early", {16'h0, digit_val}, 32'h0);
        end
        step(1);
        check("lat_digit", {16'h0, digit_val}, 32'h0002);
        check("lat_dp", {28'h0, dp_val}, 32'hF);

        // full frame 9,5,0,7 with DP on digit 1
        fv_cnt = 0;
        drive(4'b1110, 1'b1, P9); step(8);
        drive(4'b1101, 1'b0, P5); step(8);
        drive(4'b1011, 1'b1, P0); step(8);
        drive(4'b0111, 1'b1, P7); step(4);
        check("fv_before", {31'h0, frame_valid}, 32'h0);
        step(1);
        check("fv_pulse", {31'h0, frame_valid}, 32'h1);
        step(1);
        check("fv_drop", {31'h0, frame_valid}, 32'h0);
        step(2);
        check("frame_digit", {16'h0, digit_val}, 32'h7059);
        check("frame_dp", {28'h0, dp_val}, 32'hD);
        check("frame_err", {31'h0, err}, 32'h0);
        check("frame_fv_cnt", fv_cnt, 32'd1);

        // glitch restarts qualification
        drive(4'b1110, 1'b1, P3); step(3);
        check("glitch_hold", {16'h0, digit_val}, 32'h7059);
        drive(4'b1111, 1'b1, P3); step(1);
        drive(4'b1110, 1'b1, P3);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("glitch_early", {16'h0, digit_val}, 32'h7059);
        end
        step(1);
        check("glitch_cap", {16'h0, digit_val}, 32'h7053);

        // one capture per stable run: CLR mid-run must not be undone by a recapture
        drive(4'b1110, 1'b1, PX); step(5);
        check("once_err", {31'h0, err}, 32'h1);
        check("once_flags", {28'h0, err_flags}, 32'h1);
        check("once_digit", {16'h0, digit_val}, 32'h705F);
        step(1);
        pulse_clr();
        check("once_clr", {31'h0, err}, 32'h0);
        step(13);
        check("once_err_after", {31'h0, err}, 32'h0);
        check("once_flags_after", {28'h0, err_flags}, 32'h0);

        // invalid pattern on digit 2, then a valid one
        drive(4'b1011, 1'b1, PX); step(8);
        check("inv_digit", {16'h0, digit_val}, 32'h7F5F);
        check("inv_flags", {28'h0, err_flags}, 32'h4);
        check("inv_err", {31'h0, err}, 32'h1);
        drive(4'b1011, 1'b1, P4); step(8);
        check("fix_digit", {16'h0, digit_val}, 32'h745F);
        check("fix_flags", {28'h0, err_flags}, 32'h0);
        check("fix_err", {31'h0, err}, 32'h1);
        pulse_clr();
        check("clr_err", {31'h0, err}, 32'h0);

        // blanking and overlap are ignored
        drive(4'b1111, 1'b1, PX); step(10);
        drive(4'b1100, 1'b1, PX); step(10);
        check("ign_digit", {16'h0, digit_val}, 32'h745F);
        check("ign_dp", {28'h0, dp_val}, 32'hD);
        check("ign_err", {31'h0, err}, 32'h0);
        check("ign_flags", {28'h0, err_flags}, 32'h0);
        check("ign_fv_cnt", fv_cnt, 32'd1);

        // CLR on the edge capturing the last digit
        drive(4'b1110, 1'b1, P1); step(8);
        drive(4'b1101, 1'b1, P2); step(8);
        drive(4'b1011, 1'b0, P6); step(8);
        drive(4'b0111, 1'b1, P8); step(4);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clrcap_fv", {31'h0, frame_valid}, 32'h0);
        check("clrcap_digit", {16'h0, digit_val}, 32'h8621);
        check("clrcap_dp", {28'h0, dp_val}, 32'hB);
        step(3);
        check("clrcap_fv_cnt", fv_cnt, 32'd1);
        drive(4'b1110, 1'b1, P5); step(8);
        drive(4'b1101, 1'b1, P0); step(8);
        drive(4'b1011, 1'b1, P9); step(8);
        check("mask_clear", fv_cnt, 32'd1);
        drive(4'b0111, 1'b1, P7); step(8);
        check("frame2_fv_cnt", fv_cnt, 32'd2);
        check("frame2_digit", {16'h0, digit_val}, 32'h7905);
        check("frame2_dp", {28'h0, dp_val}, 32'hF);

        // reset mid-qualification
        drive(4'b1110, 1'b1, P1); step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_digit", {16'h0, digit_val}, 32'h0);
        check("mrst_dp", {28'h0, dp_val}, 32'hF);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("mrst_early", {16'h0, digit_val}, 32'h0);
        end
        step(1);
        check("mrst_cap", {16'h0, digit_val}, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side companion to the countdown timer's BCD-to-7-segment encoder.
- Monitors the multiplexed, active-low segment and anode lines that drive the display.
- Filters out scan glitches, decodes each digit's segment pattern back to BCD, and assembles a full frame of digits with their decimal points.
- Used for display read-back self-test and for bench checking of the scan driver; one instance sits in parallel with the display pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (anode lines); must be ≥1.
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; must be ≥2.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  reset; synchronous, active-high.
- SEG  in  8  segment bus. SEG[7] = DP and SEG[6:0] = g..a, all active-low.
- AN  in  DIGITS  anode enables, active-low. AN[i]=0 selects digit i.
- CLR  in  1  synchronous clear of the frame mask, ERR and ERR_FLAGS.
- DIGIT_VAL  out  4*DIGITS  decoded BCD for each digit. Digit i is in bits [4i+3:4i].
- DP_VAL  out  DIGITS  captured DP level per digit (raw, 1 = off).
- ERR_FLAGS  out  DIGITS  per-digit flag: last capture of that digit was an invalid pattern.
- ERR  out  1  sticky: any invalid pattern has been captured since the last RST or CLR.
- FRAME_VALID  out  1  one-cycle pulse when every digit has been captured since the previous pulse or clear.

Behaviour:
- Reset values: DIGIT_VAL all 0, DP_VAL all 1, ERR_FLAGS 0, ERR 0, FRAME_VALID 0. Also cleared: sample register, stability counter, captured flag, frame mask.
- Input stage: {AN,SEG} is registered into S every cycle. This is one stage, with no synchronizer.
- Stability counter CNT, width ceil(log2(STABLE_CYCLES+1)):
  - New sample ≠ S: CNT←0 and captured flag←0.
  - New sample = S: CNT increments, saturating at STABLE_CYCLES-1.
- Capture condition: all three must hold on the same cycle.
  - CNT == STABLE_CYCLES-1 and the new sample still equals S.
  - Captured flag is 0.
  - Exactly one AN bit is 0.
  - Result: captured flag←1, so there is exactly one capture per stable run.
- Latency: for an input first sampled at edge 0 and then held, the capture registers update at edge STABLE_CYCLES.
- On capture of digit i:
  - DP_VAL[i]←SEG[7].
  - SEG[6:0] is decoded to DIGIT_VAL[i] (bits shown as g..a):
    - 1000000→0
    - 1111001→1
    - 0100100→2
    - 0110000→3
    - 0011001→4
    - 0010010→5
    - 0000010→6
    - 1111000→7
    - 0000000→8
    - 0010000→9
  - Any other pattern: DIGIT_VAL[i]←4'hF, ERR_FLAGS[i]←1, ERR←1.
  - Valid pattern: ERR_FLAGS[i]←0.
  - Mask bit i←1.
- Ignored samples: AN all 1 (blanking) and AN with more than one 0 (overlap) never capture and never flag an error. CNT still tracks them normally.
- Frame completion:
  - FRAME_VALID is registered. It is 1 for the cycle after the edge at which the mask becomes all ones.
  - The mask clears at that same edge.
  - A repeated capture of an already-set digit keeps its bit at 1 and overwrites the data.
- CLR:
  - Clears mask, ERR and ERR_FLAGS next edge. DIGIT_VAL and DP_VAL are held.
  - CLR takes priority over a same-cycle capture's mask, ERR and flag updates. The data fields of that capture still update.
  - CLR also suppresses FRAME_VALID on that edge.
- RST mid-run: everything returns to its reset value on the next edge. A pattern that is held across reset must be re-qualified for the full STABLE_CYCLES.
- Simultaneous AN and SEG changes form one sample change. A one-cycle glitch restarts qualification.

Test Plan (DIGITS=4, STABLE_CYCLES=4):
- RST high 2 cycles → all outputs at reset values. Hold AN=1110, SEG=8'b1_0100100 → DIGIT_VAL[3:0]=2 and DP_VAL[0]=1 after exactly 4 edges past the first sample, with no earlier change.
- Scan digits 0..3 with patterns for 9, 5, 0, 7 (DP=0 on digit 1), each held 8 cycles → DIGIT_VAL=16'h7059, DP_VAL=4'b1101, one FRAME_VALID pulse after the digit-3 capture, ERR=0.
- Hold a pattern 3 cycles, glitch 1 cycle, restore → no capture until 4 stable samples after the restore. Hold 20 cycles → exactly one capture.
- SEG[6:0]=7'b1111111 on AN=1011 → DIGIT_VAL[11:8]=F, ERR_FLAGS=4'b0100, ERR=1. Next valid capture of digit 2 → ERR_FLAGS[2]=0, ERR still 1. Pulse CLR → ERR=0.
- AN=1111 and AN=1100 each held 10 cycles → no capture, no error, mask unchanged.
- Assert CLR on the edge that captures the last digit of a frame → FRAME_VALID stays 0, mask=0, data updated. Assert RST mid-qualification → the held pattern needs 4 fresh stable samples.
